// File: rtl/contador_param_if.sv
// rtl/contador_param_if.sv - control/status bus for one contador_param stage
interface contador_param_if #(
   parameter int WIDTH = 4
) ();
   logic             enable;
   logic             cin;
   logic [1:0]       mode;
   logic [WIDTH-1:0] D;
   logic             clr_ovf;
   logic [WIDTH-1:0] Q;
   logic             rco;
   logic             load;
   logic             ovf;
   logic             cout;

   modport master (
      output enable, cin, mode, D, clr_ovf,
      input  Q, rco, load, ovf, cout
   );

   modport slave (
      input  enable, cin, mode, D, clr_ovf,
      output Q, rco, load, ovf, cout
   );
endinterface

// File: rtl/contador_param.sv
// rtl/contador_param.sv - cascadable up/down/step/load counter with wrap or saturate policy
module contador_param #(
   parameter int WIDTH     = 4,
   parameter int STEP      = 3,
   parameter int SATURATE  = 0,
   parameter int RESET_VAL = 0
) (
   input logic              clk,
   input logic              reset,
   contador_param_if.slave  bus
);
   localparam logic [1:0]       MODE_UP   = 2'b00;
   localparam logic [1:0]       MODE_DN   = 2'b01;
   localparam logic [1:0]       MODE_STEP = 2'b10;
   localparam logic [1:0]       MODE_LOAD = 2'b11;
   localparam logic [WIDTH:0]   STEP_W    = (WIDTH+1)'(STEP);
   localparam logic [WIDTH-1:0] RST_Q     = WIDTH'(RESET_VAL);
   localparam bit               SAT       = (SATURATE != 0);

   logic [WIDTH-1:0] q;
   logic             rco_r;
   logic             load_r;
   logic             ovf_r;

   logic             act;
   logic             bnd;
   logic             count_evt;
   logic [WIDTH-1:0] nxt;
   logic [WIDTH:0]   up_w;
   logic [WIDTH:0]   dn_w;
   logic [WIDTH:0]   st_w;

   // Next-count and boundary (carry/borrow) detection, one extra bit wide
   always_comb begin
      act  = bus.enable & bus.cin;
      up_w = {1'b0, q} + {{WIDTH{1'b0}}, 1'b1};
      dn_w = {1'b0, q} - {{WIDTH{1'b0}}, 1'b1};
      st_w = {1'b0, q} - STEP_W;
      bnd  = 1'b0;
      nxt  = q;
      case (bus.mode)
         MODE_UP: begin
            bnd = up_w[WIDTH];
            nxt = (bnd && SAT) ? q : up_w[WIDTH-1:0];
         end
         MODE_DN: begin
            bnd = dn_w[WIDTH];
            nxt = (bnd && SAT) ? q : dn_w[WIDTH-1:0];
         end
         MODE_STEP: begin
            bnd = st_w[WIDTH];
            nxt = (bnd && SAT) ? '0 : st_w[WIDTH-1:0];
         end
         default: begin
            bnd = 1'b0;
            nxt = bus.D;
         end
      endcase
      count_evt = act & (bus.mode != MODE_LOAD) & bnd;
   end

   // Count/load register with pulse outputs and sticky overflow (set beats clear)
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         q      <= RST_Q;
         rco_r  <= 1'b0;
         load_r <= 1'b0;
         ovf_r  <= 1'b0;
      end else begin
         rco_r  <= 1'b0;
         load_r <= 1'b0;
         if (bus.mode == MODE_LOAD) begin
            // loading is local to this stage, so the carry-in does not gate it
            if (bus.enable) begin
               q      <= bus.D;
               load_r <= 1'b1;
            end
         end else if (act) begin
            q     <= nxt;
            rco_r <= bnd;
         end
         if (count_evt) begin
            ovf_r <= 1'b1;
         end else if (bus.clr_ovf) begin
            ovf_r <= 1'b0;
         end
      end
   end

   assign bus.Q    = q;
   assign bus.rco  = rco_r;
   assign bus.load = load_r;
   assign bus.ovf  = ovf_r;
   assign bus.cout = ~reset & count_evt;
endmodule

// File: tb/tb_contador_param.sv
// tb/tb_contador_param.sv - directed vector bench for contador_param
module tb_contador_param;
   logic clk;
   logic rst;
   int   checks;
   int   errors;

   contador_param_if #(.WIDTH(4)) s0 ();
   contador_param_if #(.WIDTH(4)) s1 ();
   contador_param_if #(.WIDTH(4)) c_lo ();
   contador_param_if #(.WIDTH(4)) c_hi ();

   contador_param #(.WIDTH(4), .STEP(3), .SATURATE(0), .RESET_VAL(0)) u_wrap (
      .clk(clk), .reset(rst), .bus(s0.slave));
   contador_param #(.WIDTH(4), .STEP(3), .SATURATE(1), .RESET_VAL(0)) u_sat (
      .clk(clk), .reset(rst), .bus(s1.slave));
   contador_param #(.WIDTH(4), .STEP(3), .SATURATE(0), .RESET_VAL(0)) u_lo (
      .clk(clk), .reset(rst), .bus(c_lo.slave));
   contador_param #(.WIDTH(4), .STEP(3), .SATURATE(0), .RESET_VAL(0)) u_hi (
      .clk(clk), .reset(rst), .bus(c_hi.slave));

   assign c_hi.cin = c_lo.cout;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      bit       en;
      bit       cin;
      bit [1:0] mode;
      bit [3:0] d;
      bit       clr;
      bit       e_cout;
      bit [3:0] e_q;
      bit       e_rco;
      bit       e_load;
      bit       e_ovf;
   } vec_t;

   vec_t vecs [18];

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input bit en, input bit cin, input bit [1:0] mode, input bit [3:0] d, input bit clr);
      @(negedge clk);
      s0.enable = en; s0.cin = cin; s0.mode = mode; s0.D = d; s0.clr_ovf = clr;
      s1.enable = en; s1.cin = cin; s1.mode = mode; s1.D = d; s1.clr_ovf = clr;
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int cnt;
      int hi_rco_cnt;
      checks = 0;
      errors = 0;

      // en cin mode d clr | cout(before edge) q rco load ovf (after edge)
      vecs[0]  = '{1, 1, 2'b11, 4'd14, 0, 0, 4'd14, 0, 1, 0};
      vecs[1]  = '{1, 1, 2'b00, 4'd0,  0, 0, 4'd15, 0, 0, 0};
      vecs[2]  = '{1, 1, 2'b00, 4'd0,  0, 1, 4'd0,  1, 0, 1};
      vecs[3]  = '{1, 1, 2'b00, 4'd0,  0, 0, 4'd1,  0, 0, 1};
      vecs[4]  = '{1, 1, 2'b00, 4'd0,  1, 0, 4'd2,  0, 0, 0};
      vecs[5]  = '{1, 1, 2'b11, 4'd5,  0, 0, 4'd5,  0, 1, 0};
      vecs[6]  = '{1, 1, 2'b10, 4'd0,  0, 0, 4'd2,  0, 0, 0};
      vecs[7]  = '{1, 1, 2'b10, 4'd0,  0, 1, 4'd15, 1, 0, 1};
      vecs[8]  = '{1, 1, 2'b10, 4'd0,  0, 0, 4'd12, 0, 0, 1};
      vecs[9]  = '{1, 1, 2'b11, 4'd0,  1, 0, 4'd0,  0, 1, 0};
      vecs[10] = '{1, 1, 2'b01, 4'd0,  0, 1, 4'd15, 1, 0, 1};
      vecs[11] = '{0, 1, 2'b00, 4'd0,  0, 0, 4'd15, 0, 0, 1};
      vecs[12] = '{1, 0, 2'b00, 4'd0,  0, 0, 4'd15, 0, 0, 1};
      vecs[13] = '{1, 0, 2'b11, 4'd7,  0, 0, 4'd7,  0, 1, 1};
      vecs[14] = '{1, 1, 2'b11, 4'd15, 0, 0, 4'd15, 0, 1, 1};
      vecs[15] = '{1, 1, 2'b00, 4'd0,  1, 1, 4'd0,  1, 0, 1};
      vecs[16] = '{1, 1, 2'b00, 4'd0,  1, 0, 4'd1,  0, 0, 0};
      vecs[17] = '{0, 0, 2'b11, 4'd9,  0, 0, 4'd1,  0, 0, 0};

      rst = 1'b1;
      s0.enable = 0; s0.cin = 1; s0.mode = 2'b00; s0.D = 0; s0.clr_ovf = 0;
      s1.enable = 0; s1.cin = 1; s1.mode = 2'b00; s1.D = 0; s1.clr_ovf = 0;
      c_lo.enable = 0; c_lo.cin = 1; c_lo.mode = 2'b00; c_lo.D = 0; c_lo.clr_ovf = 0;
      c_hi.enable = 0; c_hi.mode = 2'b00; c_hi.D = 0; c_hi.clr_ovf = 0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_q", 16'(s0.Q), 16'd0);
      chk("reset_rco", 16'(s0.rco), 16'd0);
      chk("reset_load", 16'(s0.load), 16'd0);
      chk("reset_ovf", 16'(s0.ovf), 16'd0);
      chk("reset_cout", 16'(s0.cout), 16'd0);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 18; i++) begin
         drive(vecs[i].en, vecs[i].cin, vecs[i].mode, vecs[i].d, vecs[i].clr);
         chk($sformatf("v%0d_cout", i), 16'(s0.cout), 16'(vecs[i].e_cout));
         tick();
         chk($sformatf("v%0d_q", i), 16'(s0.Q), 16'(vecs[i].e_q));
         chk($sformatf("v%0d_rco", i), 16'(s0.rco), 16'(vecs[i].e_rco));
         chk($sformatf("v%0d_load", i), 16'(s0.load), 16'(vecs[i].e_load));
         chk($sformatf("v%0d_ovf", i), 16'(s0.ovf), 16'(vecs[i].e_ovf));
      end

      // saturating instance: clamp at max, then step-down clamps at zero
      drive(1, 1, 2'b11, 4'd14, 0); tick();
      chk("sat_load14", 16'(s1.Q), 16'd14);
      drive(1, 1, 2'b00, 4'd0, 0); tick();
      chk("sat_c1_q", 16'(s1.Q), 16'd15);
      chk("sat_c1_rco", 16'(s1.rco), 16'd0);
      drive(1, 1, 2'b00, 4'd0, 0); tick();
      chk("sat_c2_q", 16'(s1.Q), 16'd15);
      chk("sat_c2_rco", 16'(s1.rco), 16'd1);
      chk("sat_c2_ovf", 16'(s1.ovf), 16'd1);
      drive(1, 1, 2'b00, 4'd0, 0); tick();
      chk("sat_c3_q", 16'(s1.Q), 16'd15);
      chk("sat_c3_rco", 16'(s1.rco), 16'd1);
      drive(1, 1, 2'b11, 4'd2, 0); tick();
      drive(1, 1, 2'b10, 4'd0, 0); tick();
      chk("sat_step_q", 16'(s1.Q), 16'd0);
      chk("sat_step_rco", 16'(s1.rco), 16'd1);
      drive(1, 1, 2'b01, 4'd0, 0); tick();
      chk("sat_dn_q", 16'(s1.Q), 16'd0);
      chk("sat_dn_rco", 16'(s1.rco), 16'd1);

      // asynchronous reset between edges while counting from 9
      drive(1, 1, 2'b11, 4'd15, 0); tick();
      drive(1, 1, 2'b00, 4'd0, 0); tick();
      drive(1, 1, 2'b11, 4'd9, 0); tick();
      chk("pre_rst_q", 16'(s0.Q), 16'd9);
      chk("pre_rst_ovf", 16'(s0.ovf), 16'd1);
      s0.mode = 2'b00;
      #2;
      rst = 1'b1;
      #1;
      chk("arst_q", 16'(s0.Q), 16'd0);
      chk("arst_load", 16'(s0.load), 16'd0);
      chk("arst_ovf", 16'(s0.ovf), 16'd0);
      chk("arst_rco", 16'(s0.rco), 16'd0);
      chk("arst_cout", 16'(s0.cout), 16'd0);
      tick();
      chk("arst_held_q", 16'(s0.Q), 16'd0);
      @(negedge clk);
      rst = 1'b0;
      tick();
      chk("arst_resume_q", 16'(s0.Q), 16'd1);

      // two stages chained into an 8-bit counter
      @(negedge clk);
      c_lo.enable = 1; c_lo.mode = 2'b11; c_lo.D = 0;
      c_hi.enable = 1; c_hi.mode = 2'b11; c_hi.D = 0;
      tick();
      chk("casc_load", 16'({c_hi.Q, c_lo.Q}), 16'd0);
      @(negedge clk);
      c_lo.mode = 2'b00;
      c_hi.mode = 2'b00;
      cnt = 0;
      hi_rco_cnt = 0;
      for (int i = 0; i < 256; i++) begin
         tick();
         cnt = (cnt + 1) % 256;
         chk($sformatf("casc_q%0d", i), 16'({c_hi.Q, c_lo.Q}), 16'(cnt));
         chk($sformatf("casc_hrco%0d", i), 16'(c_hi.rco), 16'(cnt == 0));
         if (c_hi.rco === 1'b1) hi_rco_cnt++;
      end
      chk("casc_hrco_total", 16'(hi_rco_cnt), 16'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
